// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared sizing helpers for the round-robin arbiter/mux.
//               rr_idx_w()     - width of a requester index (clog2 of CNT,
//                                never less than 1).
//               RR_LOCK_FLAG_W - width of the packet-lock flag field; the
//                                lock index field is rr_idx_w(CNT) wide.
//               RR_CNT_MIN/MAX - legal requester count range.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    localparam int RR_CNT_MIN     = 2;
    localparam int RR_CNT_MAX     = 16;
    localparam int RR_LOCK_FLAG_W = 1;

    function automatic int rr_idx_w(input int cnt);
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/one_hot_mux.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_mux
// Description : AND-OR data selector driven by a one-hot select vector.
//               ONE_HOT_CHECK != 0 flags selects with more than one bit set.
// Ports       : sel      [CNT]        one-hot select
//               in_data  [WIDTH*CNT]  packed inputs, input i at [i*WIDTH +: WIDTH]
//               out_data [WIDTH]      selected data (0 when sel == 0)
//               err      [1]          multi-hot select (0 when check disabled)
// Revision    : 1.0 - initial release
// ============================================================================
module one_hot_mux #(
    parameter int WIDTH         = 32,
    parameter int CNT           = 4,
    parameter int ONE_HOT_CHECK = 0
) (
    input  logic [CNT-1:0]       sel,
    input  logic [WIDTH*CNT-1:0] in_data,
    output logic [WIDTH-1:0]     out_data,
    output logic                 err
);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < CNT; i++) begin
            out_data = out_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
        end
    end

    generate
        if (ONE_HOT_CHECK != 0) begin : g_check
            // x & (x-1) clears the lowest set bit; anything left means multi-hot
            assign err = |(sel & (sel - CNT'(1)));
        end else begin : g_no_check
            assign err = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux_ff.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux_ff
// Description : Round-robin arbiter feeding a registered output stage.
//               The grant is the first valid requester scanning upward from a
//               rotating pointer; the winner's data is captured into a
//               single output register whenever that register is free or
//               being drained (load = !out_vld || out_rdy).
//               Optional feature macro: RR_ARB_PKT_LOCK_EN - holds the grant
//               on one requester from its first beat until the in_last beat.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               in_vld  [CNT]            per-requester valid
//               in_data [WIDTH*CNT]      packed requester data
//               in_last [CNT]            end-of-packet (lock build only)
//               in_rdy  [CNT]            per-requester accept (at most one set)
//               out_vld/out_data/out_src registered output, source index
//               out_rdy                  downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux_ff
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT-1:0]          in_vld,
    input  logic [WIDTH*CNT-1:0]    in_data,
    input  logic [CNT-1:0]          in_last,
    output logic [CNT-1:0]          in_rdy,
    output logic                    out_vld,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(CNT)-1:0]  out_src,
    input  logic                    out_rdy
);

    localparam int IDX_W = rr_idx_w(CNT);

    generate
        if (CNT < RR_CNT_MIN || CNT > RR_CNT_MAX) begin : g_bad_cnt
            $error("rr_arb_mux_ff: CNT out of range");
        end
    endgenerate

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_src_q, out_src_d;

    logic             w_load;
    logic             w_xfer;
    logic [CNT-1:0]   w_scan_grant;
    logic [IDX_W-1:0] w_scan_idx;
    logic [CNT-1:0]   w_grant;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_ptr_next;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_err_unused;

    // Rotating priority scan: offset k from ptr, wrapping CNT-1 -> 0.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] j_idx;
        logic             found;
        w_scan_grant = '0;
        w_scan_idx   = '0;
        found        = 1'b0;
        j            = 0;
        j_idx        = '0;
        for (int k = 0; k < CNT; k++) begin
            j = int'(ptr_q) + k;
            if (j >= CNT) begin
                j = j - CNT;
            end
            j_idx = IDX_W'(j);
            if (!found && in_vld[j_idx]) begin
                found        = 1'b1;
                w_scan_idx   = j_idx;
                w_scan_grant = CNT'(1) << j_idx;
            end
        end
    end

`ifdef RR_ARB_PKT_LOCK_EN
    logic [RR_LOCK_FLAG_W-1:0] locked_q, locked_d;
    logic [IDX_W-1:0]          lock_idx_q, lock_idx_d;

    // While a packet is open only its owner may be granted, and only when
    // it is presenting a beat; everyone else sees no grant.
    always_comb begin
        if (locked_q[0]) begin
            w_grant   = in_vld[lock_idx_q] ? (CNT'(1) << lock_idx_q) : '0;
            w_gnt_idx = lock_idx_q;
        end else begin
            w_grant   = w_scan_grant;
            w_gnt_idx = w_scan_idx;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^in_last;
    assign w_grant       = w_scan_grant;
    assign w_gnt_idx     = w_scan_idx;
`endif

    assign w_load     = !out_vld_q || out_rdy;
    assign in_rdy     = rst ? '0 : (w_grant & {CNT{w_load}});
    assign w_xfer     = |(in_rdy & in_vld);
    assign w_ptr_next = (w_gnt_idx == IDX_W'(CNT-1)) ? '0 : (w_gnt_idx + IDX_W'(1));

    one_hot_mux #(
        .WIDTH         (WIDTH),
        .CNT           (CNT),
        .ONE_HOT_CHECK (0)
    ) u_data_mux (
        .sel      (w_grant),
        .in_data  (in_data),
        .out_data (w_mux_data),
        .err      (w_mux_err_unused)
    );

    // Output register: loads on every free/draining cycle; data and source
    // only change on an actual transfer so they hold across idle cycles.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (w_load) begin
            out_vld_d = w_xfer;
            if (w_xfer) begin
                out_data_d = w_mux_data;
                out_src_d  = w_gnt_idx;
            end
        end
    end

`ifdef RR_ARB_PKT_LOCK_EN
    // The pointer only advances on the closing beat, so a packet counts as
    // one round-robin turn regardless of its length.
    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (w_xfer) begin
            if (in_last[w_gnt_idx]) begin
                locked_d = '0;
                ptr_d    = w_ptr_next;
            end else begin
                locked_d   = RR_LOCK_FLAG_W'(1);
                lock_idx_d = w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (w_xfer) begin
            ptr_d = w_ptr_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= '0;
            ptr_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux_ff.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_mux_ff
// Description : Self-checking bench for rr_arb_mux_ff (WIDTH=32, CNT=5).
//               Directed scenarios plus randomized traffic against a
//               behavioural reference model and an in-order scoreboard.
//               Honours RR_ARB_PKT_LOCK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux_ff;

    localparam int WIDTH = 32;
    localparam int CNT   = 5;
    localparam int IW    = $clog2(CNT);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CNT-1:0]       in_vld;
    logic [WIDTH*CNT-1:0] in_data;
    logic [CNT-1:0]       in_last;
    logic [CNT-1:0]       in_rdy;
    logic                 out_vld;
    logic [WIDTH-1:0]     out_data;
    logic [IW-1:0]        out_src;
    logic                 out_rdy;

    always #5 clk = ~clk;

    rr_arb_mux_ff #(
        .WIDTH (WIDTH),
        .CNT   (CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_src  (out_src),
        .out_rdy  (out_rdy)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int               src;
        logic [WIDTH-1:0] data;
    } sb_t;

    sb_t              sb_q[$];
    bit               m_known = 1'b0;
    bit               m_vld   = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_src   = 0;
    int               m_ptr   = 0;
    bit               m_locked = 1'b0;
    int               m_lock_idx = 0;
    int               waits[CNT];

    function automatic int pick(input logic [CNT-1:0] v, input int p);
        for (int k = 0; k < CNT; k++) begin
            if (v[(p + k) % CNT]) return (p + k) % CNT;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < CNT; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
    endtask

    // One clock: check outputs against the model at the falling edge, then
    // advance the model with what the rising edge will see.
    task automatic tick();
        int               g;
        bit               load, p_rst, p_last;
        logic [CNT-1:0]   p_vld;
        logic [WIDTH-1:0] p_data;
        logic [CNT-1:0]   exp_rdy;
        sb_t              e;
        @(negedge clk);
        g = -1;
        load = !m_vld || out_rdy;
        if (!rst && load) begin
`ifdef RR_ARB_PKT_LOCK_EN
            if (m_locked) g = in_vld[m_lock_idx] ? m_lock_idx : -1;
            else          g = pick(in_vld, m_ptr);
`else
            g = pick(in_vld, m_ptr);
`endif
        end
        exp_rdy = (g >= 0) ? CNT'(1 << g) : '0;
        if (m_known) begin
            check("out_vld", out_vld, m_vld);
            check("out_data", out_data, m_data);
            check("out_src", out_src, m_src);
            check("in_rdy", in_rdy, exp_rdy);
            check("rdy_onehot", $countones(in_rdy) <= 1, 1);
            if (!rst && out_vld && out_rdy) begin
                check("sb_avail", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_src", out_src, e.src);
                end
            end
        end
        p_rst  = rst;
        p_vld  = in_vld;
        p_data = (g >= 0) ? in_data[g*WIDTH +: WIDTH] : '0;
        p_last = (g >= 0) ? in_last[g] : 1'b0;
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_known = 1'b1; m_vld = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
            m_locked = 1'b0;
            sb_q.delete();
            for (int i = 0; i < CNT; i++) waits[i] = 0;
        end else if (g >= 0) begin
            m_vld = 1'b1; m_data = p_data; m_src = g;
            sb_q.push_back('{src: g, data: p_data});
`ifdef RR_ARB_PKT_LOCK_EN
            if (p_last) begin
                m_locked = 1'b0;
                m_ptr = (g + 1) % CNT;
            end else begin
                m_locked = 1'b1;
                m_lock_idx = g;
            end
`else
            m_ptr = (g + 1) % CNT;
            for (int i = 0; i < CNT; i++) begin
                if (i == g) begin
                    check("fair_wait", waits[i] <= CNT - 1, 1);
                    waits[i] = 0;
                end else if (p_vld[i]) begin
                    waits[i]++;
                end else begin
                    waits[i] = 0;
                end
            end
`endif
        end else if (load) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_vld = '1; rand_data();
        tick();
        check("rst_in_rdy", in_rdy, '0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int               rr_seq[6];
        int               pk_seq[4];
        logic [WIDTH-1:0] d3;
        rst = 1'b1; in_vld = '0; in_last = '0; in_data = '0; out_rdy = 1'b0;
        rr_seq = '{0, 2, 4, 0, 2, 4};
`ifdef RR_ARB_PKT_LOCK_EN
        pk_seq = '{1, 1, 1, 2};
`else
        pk_seq = '{1, 2, 1, 2};
`endif

        // reset state
        do_reset();
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);

        // fixed alternating requesters, free-running output
        in_vld = 5'b10101; out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            tick();
            check("rr_seq_src", out_src, rr_seq[k]);
            check("rr_seq_vld", out_vld, 1);
        end

        // stall with a single requester
        do_reset();
        in_vld = 5'b01000; out_rdy = 1'b1; rand_data();
        tick();
        check("stall_first_src", out_src, 3);
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_data();
            tick();
            check("stall_vld", out_vld, 1);
            check("stall_src", out_src, 3);
            check("stall_rdy", in_rdy, '0);
        end
        out_rdy = 1'b1; rand_data(); d3 = in_data[3*WIDTH +: WIDTH];
        #1;
        check("resume_rdy", in_rdy, 5'b01000);
        tick();
        check("resume_vld", out_vld, 1);
        check("resume_data", out_data, d3);

        // reset with output full and ptr=3
        do_reset();
        in_vld = 5'b00100; out_rdy = 1'b1; rand_data();
        tick();
        check("pre_rst_vld", out_vld, 1);
        rst = 1'b1; in_vld = 5'b11111;
        #1;
        check("mid_rst_rdy", in_rdy, '0);
        tick();
        check("post_rst_vld", out_vld, 0);
        check("post_rst_data", out_data, 0);
        check("post_rst_src", out_src, 0);
        rst = 1'b0; in_vld = 5'b10110; rand_data();
        tick();
        check("post_rst_grant", out_src, 1);

        // requester 1 sends a 3-beat packet against requester 2
        do_reset();
        in_vld = 5'b00110; out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_last = (k == 2) ? 5'b00110 : 5'b00100;
            rand_data();
            tick();
            check("pkt_src", out_src, pk_seq[k]);
        end

        // random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            in_vld  = CNT'($urandom);
            in_last = CNT'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 499) == 0);
            rand_data();
            tick();
        end
        rst = 1'b0; in_vld = '0; out_rdy = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arb_mux_ff.md
RR_ARB_MUX_FF -- requirements
Module: rr_arb_mux_ff

Interface
REQ-001 Parameter WIDTH, default 32: data width per requester, in bits.
REQ-002 Parameter CNT, default 5: number of requesters; legal range is 2..16.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_vld, input, CNT: per-requester valid.
REQ-006 Port in_data, input, WIDTH*CNT: packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_last, input, CNT: per-requester end-of-packet flag; used only when RR_ARB_PKT_LOCK_EN is defined.
REQ-008 Port in_rdy, output, CNT: per-requester accept; at most one bit is set in any cycle.
REQ-009 Port out_vld, output, 1: registered output valid.
REQ-010 Port out_data, output, WIDTH: registered selected data.
REQ-011 Port out_src, output, $clog2(CNT): registered index of the granted requester.
REQ-012 Port out_rdy, input, 1: downstream accept.

Function
REQ-013 load = !out_vld || out_rdy; the output register captures new data only when load=1.
REQ-014 The grant shall be a one-hot combinational vector: the first set bit of in_vld, scanning from pointer ptr upward and wrapping CNT-1 -> 0.
REQ-015 in_rdy shall equal grant & {CNT{load}}; a transfer on requester i occurs when in_vld[i] && in_rdy[i].
REQ-016 On a transfer: out_vld <= 1, out_data <= the granted slice, out_src <= the granted index; latency from in to out is 1 cycle.
REQ-017 When load=1 and no in_vld bit is set: out_vld <= 0, and out_data and out_src hold their values.
REQ-018 When out_vld=1 and out_rdy=0: the output register holds, and in_rdy = 0.
REQ-019 On a transfer from index g: ptr <= g+1, with g = CNT-1 wrapping to 0. With no transfer, ptr holds.
REQ-020 Throughput: with out_rdy held at 1, one transfer per cycle.
REQ-021 in_vld may change while the output is stalled; the grant is re-evaluated every cycle, and no fairness state moves without a transfer.

Reset
REQ-022 When rst=1 at a clk edge: out_vld <= 0, out_data <= 0, out_src <= 0, ptr <= 0, lock state cleared.
REQ-023 Reset takes priority over any simultaneous transfer, and in_rdy shall be 0 while rst=1.
REQ-024 Reset asserted mid-packet drops the lock; no partial-packet recovery is performed.

Configuration
REQ-025 Macro RR_ARB_PKT_LOCK_EN defined: packet lock is enabled.
- A transfer with in_last[g]=0 sets locked=1 and lock_idx=g.
- While locked, grant = in_vld[lock_idx] ? onehot(lock_idx) : 0, and other requesters are blocked.
- A transfer with in_last=1 clears locked; ptr updates only on that transfer.
REQ-026 Macro undefined: in_last is ignored, no lock registers exist, and every transfer is an independent single-beat packet.

Structure
REQ-027 Package rr_arb_pkg shall hold the index-width function (clog2 of CNT) and a localparam for the lock-state field widths.
REQ-028 The data selection shall reuse the existing one_hot_mux sub-module (WIDTH, CNT, ONE_HOT_CHECK=0, err left open), driven by grant.
REQ-029 The arbiter's priority scan and pointer logic live in this module; no further sub-modules.

Verification
REQ-030 CNT=5, in_vld=5'b10101 constant, out_rdy=1 -> out_src sequence 0,2,4,0,2,… on consecutive cycles.
REQ-031 Single requester 3 valid, out_rdy=0 for 4 cycles after the first transfer -> out_vld stays 1, out_src=3, in_rdy=0 during the stall; the transfer resumes the cycle after out_rdy=1.
REQ-032 Reset asserted while out_vld=1 and ptr=3 -> next cycle out_vld=0, out_data=0, out_src=0; the first grant after release goes to the lowest valid index.
REQ-033 RR_ARB_PKT_LOCK_EN, requesters 1 and 2 both valid, requester 1 sends a 3-beat packet (last on beat 3) -> three consecutive out_src=1, then out_src=2.
REQ-034 Without the macro, same stimulus as REQ-033 -> out_src alternates 1,2,1,2.
REQ-035 Random in_vld and out_rdy for 10k cycles -> at most one in_rdy bit per cycle, in/out data match in order via a scoreboard, and no requester waits more than CNT transfers (non-lock build).
